// File: rtl/div_pkg.sv
// Shared types and op-decode helpers for the divider issue controller.
//   div_op_e    : M-extension divide opcode as presented by the execute stage
//   div_state_e : issue FSM state
//   is_rem      : op returns the remainder rather than the quotient
//   is_signed   : op treats operands as two's complement
package div_pkg;

    typedef enum logic [1:0] {
        OpDiv  = 2'b00,
        OpDivu = 2'b01,
        OpRem  = 2'b10,
        OpRemu = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StWait,
        StResp
    } div_state_e;

    function automatic logic is_rem(div_op_e op);
        return (op == OpRem) || (op == OpRemu);
    endfunction

    function automatic logic is_signed(div_op_e op);
        return (op == OpDiv) || (op == OpRem);
    endfunction

endpackage

// File: rtl/div_result_cache.sv
// Single-entry store of the last completed division, used to skip the divider when
// the same operands come back (typical DIV followed by REM on the same pair).
// Only built when DIV_REUSE_EN is defined.
// Ports:
//   clk_i, reset_i     : clock, async active-high reset (invalidates the entry)
//   flush_i            : invalidates the entry
//   store_i            : write rs1/rs2/sign/quotient/remainder of a finished division
//   lookup_*           : operands of the request being offered in IDLE
//   hit_o              : entry valid and rs1/rs2/sign all match
//   data_o             : cached remainder (lookup_rem_i) or quotient
`ifdef DIV_REUSE_EN
module div_result_cache #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            flush_i,
    input  logic            store_i,
    input  logic [XLEN-1:0] store_rs1_i,
    input  logic [XLEN-1:0] store_rs2_i,
    input  logic            store_sign_i,
    input  logic [XLEN-1:0] store_quot_i,
    input  logic [XLEN-1:0] store_rem_i,
    input  logic [XLEN-1:0] lookup_rs1_i,
    input  logic [XLEN-1:0] lookup_rs2_i,
    input  logic            lookup_sign_i,
    input  logic            lookup_rem_i,
    output logic            hit_o,
    output logic [XLEN-1:0] data_o
);

    logic            valid_q;
    logic [XLEN-1:0] rs1_q, rs2_q, quot_q, rem_q;
    logic            sign_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_q <= 1'b0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            sign_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (store_i) begin
            valid_q <= 1'b1;
            rs1_q   <= store_rs1_i;
            rs2_q   <= store_rs2_i;
            sign_q  <= store_sign_i;
            quot_q  <= store_quot_i;
            rem_q   <= store_rem_i;
        end
    end

    assign hit_o  = valid_q && (rs1_q == lookup_rs1_i) && (rs2_q == lookup_rs2_i)
                    && (sign_q == lookup_sign_i);
    assign data_o = lookup_rem_i ? rem_q : quot_q;

endmodule
`endif

// File: rtl/div_issue_ctrl.sv
// Issue/retire controller between the M-extension execute stage and the iterative divider.
// Registers one request, holds the divider's start high through LOAD/WAIT, captures the
// quotient or remainder into a response register and presents it on a valid/ready handshake.
// Optional feature: define DIV_REUSE_EN to add a one-entry result cache (div_result_cache).
// Ports:
//   clk_i, reset_i      : clock, async active-high reset
//   stall_i, flush_i    : pipeline stall (freeze) / abort in-flight request
//   req_*               : request handshake, op, operands, tag
//   rsp_*               : response handshake, result data, tag
//   div_*               : divider interface (start/sign/stall/operands out, results/valid in)
//   busy_o              : FSM not idle
module div_issue_ctrl
    import div_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_op_i,
    input  logic [XLEN-1:0]  req_rs1_i,
    input  logic [XLEN-1:0]  req_rs2_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [XLEN-1:0]  rsp_data_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic             div_start_o,
    output logic             div_sign_o,
    output logic             div_stall_o,
    output logic [XLEN-1:0]  div_dividend_o,
    output logic [XLEN-1:0]  div_divisor_o,
    input  logic [XLEN-1:0]  div_quotient_i,
    input  logic [XLEN-1:0]  div_remainder_i,
    input  logic             div_valid_i,
    output logic             busy_o
);

    div_state_e       state_q, state_d;
    div_op_e          op_q;
    logic [XLEN-1:0]  rs1_q, rs2_q;
    logic [TAG_W-1:0] tag_q;
    logic [XLEN-1:0]  data_q, data_d;
    logic             accept;
    logic             hit;
    logic [XLEN-1:0]  hit_data;

    // Flush and stall both block acceptance; flush wins over stall everywhere.
    assign req_ready_o = (state_q == StIdle) && !stall_i && !flush_i;
    assign accept      = req_valid_i && req_ready_o;

`ifdef DIV_REUSE_EN
    logic capture;
    assign capture = (state_q == StWait) && div_valid_i && !stall_i && !flush_i;

    div_result_cache #(
        .XLEN (XLEN)
    ) u_cache (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .flush_i       (flush_i),
        .store_i       (capture),
        .store_rs1_i   (rs1_q),
        .store_rs2_i   (rs2_q),
        .store_sign_i  (is_signed(op_q)),
        .store_quot_i  (div_quotient_i),
        .store_rem_i   (div_remainder_i),
        .lookup_rs1_i  (req_rs1_i),
        .lookup_rs2_i  (req_rs2_i),
        .lookup_sign_i (is_signed(div_op_e'(req_op_i))),
        .lookup_rem_i  (is_rem(div_op_e'(req_op_i))),
        .hit_o         (hit),
        .data_o        (hit_data)
    );
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (flush_i) begin
            state_d = StIdle;
        end else if (!stall_i) begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        state_d = hit ? StResp : StLoad;
                        if (hit) data_d = hit_data;
                    end
                end
                // Divider samples operands this cycle; its valid is stale, so skip it.
                StLoad: state_d = StWait;
                StWait: begin
                    if (div_valid_i) begin
                        state_d = StResp;
                        data_d  = is_rem(op_q) ? div_remainder_i : div_quotient_i;
                    end
                end
                StResp: begin
                    if (rsp_ready_i) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // Operands only change on acceptance, so they stay stable for the whole LOAD..RESP span.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            op_q  <= OpDiv;
            rs1_q <= '0;
            rs2_q <= '0;
            tag_q <= '0;
        end else if (accept) begin
            op_q  <= div_op_e'(req_op_i);
            rs1_q <= req_rs1_i;
            rs2_q <= req_rs2_i;
            tag_q <= req_tag_i;
        end
    end

    assign rsp_valid_o    = (state_q == StResp);
    assign rsp_data_o     = data_q;
    assign rsp_tag_o      = tag_q;
    // Dropping start outside LOAD/WAIT is what resets the divider.
    assign div_start_o    = (state_q == StLoad) || (state_q == StWait);
    assign div_sign_o     = is_signed(op_q);
    assign div_stall_o    = stall_i;
    assign div_dividend_o = rs1_q;
    assign div_divisor_o  = rs2_q;
    assign busy_o         = (state_q != StIdle);

endmodule

// File: tb/tb_div_issue_ctrl.sv
module tb_div_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, flush;
    logic        req_valid, req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_rs1, req_rs2;
    logic [4:0]  req_tag;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_tag;
    logic        div_start, div_sign, div_stall;
    logic [31:0] div_dividend, div_divisor, div_quotient, div_remainder;
    logic        div_valid, busy;

    int checks   = 0;
    int failures = 0;
    int start_cycles = 0;

    always #5 clk = ~clk;

    div_issue_ctrl #(
        .XLEN  (32),
        .TAG_W (5)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .stall_i         (stall),
        .flush_i         (flush),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_op_i        (req_op),
        .req_rs1_i       (req_rs1),
        .req_rs2_i       (req_rs2),
        .req_tag_i       (req_tag),
        .rsp_valid_o     (rsp_valid),
        .rsp_ready_i     (rsp_ready),
        .rsp_data_o      (rsp_data),
        .rsp_tag_o       (rsp_tag),
        .div_start_o     (div_start),
        .div_sign_o      (div_sign),
        .div_stall_o     (div_stall),
        .div_dividend_o  (div_dividend),
        .div_divisor_o   (div_divisor),
        .div_quotient_i  (div_quotient),
        .div_remainder_i (div_remainder),
        .div_valid_i     (div_valid),
        .busy_o          (busy)
    );

    // Behavioural iterative divider: loads on the first start cycle, spends one setup
    // cycle and then one cycle per significant dividend bit (min 3); /0 and overflow take 3.
    function automatic int sig_bits(logic [31:0] a, logic [31:0] b, logic s);
        logic [31:0] m;
        int n;
        if (b == 32'd0) return 3;
        if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 3;
        m = (s && a[31]) ? (32'd0 - a) : a;
        n = 0;
        for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
        return (n < 3) ? 3 : n;
    endfunction

    function automatic logic [31:0] ref_q(logic [31:0] a, logic [31:0] b, logic s);
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        if (s) return $signed(a) / $signed(b);
        return a / b;
    endfunction

    function automatic logic [31:0] ref_r(logic [31:0] a, logic [31:0] b, logic s);
        if (b == 32'd0) return a;
        if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        if (s) return $signed(a) % $signed(b);
        return a % b;
    endfunction

    logic dv_loaded;
    int   dv_cnt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            dv_loaded     <= 1'b0;
            dv_cnt        <= 0;
            div_quotient  <= 32'd0;
            div_remainder <= 32'd0;
        end else if (!div_start) begin
            dv_loaded <= 1'b0;
        end else if (!div_stall) begin
            if (!dv_loaded) begin
                dv_loaded     <= 1'b1;
                dv_cnt        <= sig_bits(div_dividend, div_divisor, div_sign) + 1;
                div_quotient  <= ref_q(div_dividend, div_divisor, div_sign);
                div_remainder <= ref_r(div_dividend, div_divisor, div_sign);
            end else if (dv_cnt != 0) begin
                dv_cnt <= dv_cnt - 1;
            end
        end
    end

    assign div_valid = !dv_loaded || (dv_cnt == 0);

    always @(posedge clk) if (div_start) start_cycles <= start_cycles + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_rs1   = a;
        req_rs2   = b;
        req_tag   = tag;
        #1;
        chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int start, output int lat);
        lat = start;
        while (lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (rsp_valid) break;
        end
    endtask

    task automatic complete(input string name, input logic [31:0] exp_data,
                            input logic [4:0] exp_tag, input int exp_lat, input int lat);
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_data"}, {32'd0, rsp_data}, {32'd0, exp_data});
        chk({name, "_tag"}, {59'd0, rsp_tag}, {59'd0, exp_tag});
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk({name, "_rsp_drop"}, {63'd0, rsp_valid}, 64'd0);
    endtask

    task automatic run(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag,
                       input logic [31:0] exp_data, input int exp_lat);
        int lat;
        issue(op, a, b, tag);
        wait_rsp(0, lat);
        complete(name, exp_data, tag, exp_lat, lat);
    endtask

    initial begin
        int lat;
        int seen;
        int sc0;
        reset     = 1'b1;
        stall     = 1'b0;
        flush     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_rs1   = 32'd0;
        req_rs2   = 32'd0;
        req_tag   = 5'd0;
        rsp_ready = 1'b0;
        #1;
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_div_start", {63'd0, div_start}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_data_tag", {27'd0, rsp_tag, rsp_data}, 64'd0);
        chk("rst_operands", {div_dividend, div_divisor}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Basic unsigned and signed results, tag echo, bits+3 latency
        run("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd3, 32'd14, 10);
        run("remu_100_7", 2'b11, 32'd100, 32'd7, 5'd4, 32'd2, 10);
        run("div_m100_7", 2'b00, 32'hFFFF_FF9C, 32'd7, 5'd5, 32'hFFFF_FFF2, 10);
        run("rem_m100_7", 2'b10, 32'hFFFF_FF9C, 32'd7, 5'd6, 32'hFFFF_FFFE, 10);
        run("div_by_0", 2'b00, 32'd5, 32'd0, 5'd7, 32'hFFFF_FFFF, 6);
        run("rem_by_0", 2'b10, 32'h1234, 32'd0, 5'd8, 32'h1234, 6);
        run("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000, 6);
        run("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'd0, 6);

        // Backpressure: result held for 10 cycles, no new request accepted
        issue(2'b01, 32'd100, 32'd7, 5'd11);
        wait_rsp(0, lat);
        repeat (10) @(posedge clk);
        #1;
        chk("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("bp_data", {32'd0, rsp_data}, 64'd14);
        chk("bp_req_ready", {63'd0, req_ready}, 64'd0);
        complete("bp", 32'd14, 5'd11, 10, lat);

        // Stall for 4 cycles in WAIT adds 4 cycles; stall in RESP holds the result
        issue(2'b01, 32'd100, 32'd7, 5'd12);
        repeat (3) @(posedge clk);
        @(negedge clk);
        stall = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("stall_div_stall", {63'd0, div_stall}, 64'd1);
        chk("stall_start_held", {63'd0, div_start}, 64'd1);
        @(negedge clk);
        stall = 1'b0;
        wait_rsp(7, lat);
        @(negedge clk);
        stall     = 1'b1;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("stall_rsp_held", {63'd0, rsp_valid}, 64'd1);
        chk("stall_req_ready", {63'd0, req_ready}, 64'd0);
        @(negedge clk);
        stall     = 1'b0;
        rsp_ready = 1'b0;
        complete("stall", 32'd14, 5'd12, 14, lat);

        // Stall in IDLE blocks acceptance
        @(negedge clk);
        stall     = 1'b1;
        req_valid = 1'b1;
        #1;
        chk("idle_stall_ready", {63'd0, req_ready}, 64'd0);
        @(posedge clk);
        #1;
        chk("idle_stall_busy", {63'd0, busy}, 64'd0);
        req_valid = 1'b0;
        stall     = 1'b0;

        // Flush in WAIT drops the request; next request unaffected
        issue(2'b01, 32'd100, 32'd7, 5'd13);
        repeat (4) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy", {63'd0, busy}, 64'd0);
        chk("flush_start", {63'd0, div_start}, 64'd0);
        seen = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen++;
        end
        chk("flush_no_rsp", seen, 0);
        run("post_flush", 2'b01, 32'd9, 32'd3, 5'd14, 32'd3, 7);

        // A request alongside flush is not accepted
        @(negedge clk);
        req_valid = 1'b1;
        flush     = 1'b1;
        #1;
        chk("flush_req_ready", {63'd0, req_ready}, 64'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        chk("flush_req_busy", {63'd0, busy}, 64'd0);

        // Reset mid-operation
        issue(2'b01, 32'd100, 32'd7, 5'd15);
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_start", {63'd0, div_start}, 64'd0);
        chk("midrst_ready", {63'd0, req_ready}, 64'd1);
        chk("midrst_tag", {59'd0, rsp_tag}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen++;
        end
        chk("midrst_no_rsp", seen, 0);

        // Same operands twice: cached result when reuse is built in
        run("div_50_6", 2'b00, 32'd50, 32'd6, 5'd16, 32'd8, 9);
        sc0 = start_cycles;
`ifdef DIV_REUSE_EN
        run("rem_50_6_hit", 2'b10, 32'd50, 32'd6, 5'd17, 32'd2, 1);
        chk("reuse_no_start", start_cycles - sc0, 0);
`else
        run("rem_50_6", 2'b10, 32'd50, 32'd6, 5'd17, 32'd2, 9);
        chk("noreuse_started", {63'd0, (start_cycles - sc0) > 0}, 64'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
